// File: rtl/capture_if.sv
// capture_if: bundle between the trigger-config/trigger/decimator side and the
// capture sequencer.
//   master (trigger side / host): drives run, capture_done, wrt_smpl,
//                                 triggered, trig_pos
//   slave  (capture_ctrl)       : drives we, waddr, armed, set_capture_done,
//                                 trig_addr
interface capture_if #(
    parameter int AW = 9
) ();
    logic          run;
    logic          capture_done;
    logic          wrt_smpl;
    logic          triggered;
    logic [AW-1:0] trig_pos;
    logic          we;
    logic [AW-1:0] waddr;
    logic          armed;
    logic          set_capture_done;
    logic [AW-1:0] trig_addr;

    modport master (
        output run, capture_done, wrt_smpl, triggered, trig_pos,
        input  we, waddr, armed, set_capture_done, trig_addr
    );

    modport slave (
        input  run, capture_done, wrt_smpl, triggered, trig_pos,
        output we, waddr, armed, set_capture_done, trig_addr
    );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: capture sequencer for the logic-analyzer sample RAM.
// Owns the circular write pointer, raises armed once the pre-trigger window
// is full, counts post-trigger samples and pulses set_capture_done when the
// capture completes, latching the readout start address in trig_addr.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - capture_if.slave (run/capture_done/wrt_smpl/triggered/trig_pos in,
//            we/waddr/armed/set_capture_done/trig_addr out)
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  logic     clk,
    input  logic     rst_n,
    capture_if.slave bus
);
    localparam logic [AW:0]   L_ENT  = (AW+1)'(ENTRIES);
    localparam logic [AW:0]   L_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] L_LAST = AW'(ENTRIES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [AW-1:0] r_waddr, r_trig_addr, w_waddr_inc;
    logic [AW:0]   r_smpl_cnt, r_trig_cnt;
    logic [AW:0]   w_smpl_inc, w_trig_inc, w_tp_eff, w_arm_thr;
    logic          r_armed, r_set_done;
    logic          w_we, w_start, w_abort, w_done;

    // Effective post-trigger length: 0 means 1, anything past the RAM means
    // ENTRIES-1 so at least one pre-trigger sample always survives.
    always_comb begin
        w_tp_eff = {1'b0, bus.trig_pos};
        if (bus.trig_pos == '0)
            w_tp_eff = L_ONE;
        else if ({1'b0, bus.trig_pos} >= L_ENT)
            w_tp_eff = L_ENT - L_ONE;
    end

    assign w_arm_thr   = L_ENT - w_tp_eff;
    assign w_waddr_inc = (r_waddr == L_LAST) ? '0 : r_waddr + AW'(1);
    assign w_smpl_inc  = (r_smpl_cnt == L_ENT) ? L_ENT : r_smpl_cnt + L_ONE;
    assign w_trig_inc  = r_trig_cnt + L_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.run && !bus.capture_done) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // Abort wins over a strobe in the same cycle; that sample is dropped.
                if (!bus.run) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_we = bus.wrt_smpl;
                    if (bus.wrt_smpl && r_armed && bus.triggered &&
                        (w_trig_inc == w_tp_eff)) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Hold until the host-visible done bit is set, so a re-arm
                // has to wait for the host to clear it.
                if (bus.capture_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr     <= '0;
            r_trig_addr <= '0;
            r_smpl_cnt  <= '0;
            r_trig_cnt  <= '0;
            r_armed     <= 1'b0;
            r_set_done  <= 1'b0;
        end else begin
            r_set_done <= w_done;
            if (w_start) begin
                r_waddr    <= '0;
                r_smpl_cnt <= '0;
                r_trig_cnt <= '0;
                r_armed    <= 1'b0;
            end else if (w_abort) begin
                r_armed <= 1'b0;
            end else if (w_we) begin
                r_waddr    <= w_waddr_inc;
                r_smpl_cnt <= w_smpl_inc;
                // smpl_cnt saturates at ENTRIES, above any threshold, so this fires once.
                if (w_smpl_inc == w_arm_thr) r_armed <= 1'b1;
                if (r_armed && bus.triggered) r_trig_cnt <= w_trig_inc;
                // Next write slot after the last post-trigger sample holds the oldest sample.
                if (w_done) begin
                    r_armed     <= 1'b0;
                    r_trig_addr <= w_waddr_inc;
                end
            end
        end
    end

    assign bus.we               = w_we;
    assign bus.waddr            = r_waddr;
    assign bus.armed            = r_armed;
    assign bus.set_capture_done = r_set_done;
    assign bus.trig_addr        = r_trig_addr;
endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;
    localparam int ENTRIES = 384;
    localparam int AW      = $clog2(ENTRIES);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    capture_if #(.AW(AW)) bus ();
    capture_ctrl #(.ENTRIES(ENTRIES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: samples written this capture as an unbounded count,
    // addresses derived by modulo.
    bit m_cap, m_wait, m_armed, m_pulse;
    int m_n, m_post, m_taddr;

    // Observation of the DUT for directed checks
    int n_we, arm_n, done_n, pulse_cnt;

    function automatic int eff(input int tp);
        if (tp == 0) return 1;
        if (tp >= ENTRIES) return ENTRIES - 1;
        return tp;
    endfunction

    function automatic void model_reset();
        m_cap = 0; m_wait = 0; m_armed = 0; m_pulse = 0;
        m_n = 0; m_post = 0; m_taddr = 0;
    endfunction

    function automatic void model_step(input bit r, input bit cd, input bit ws,
                                       input bit trg, input int tp);
        int te;
        bit was;
        te = eff(tp);
        was = m_armed;
        m_pulse = 0;
        if (m_cap) begin
            if (!r) begin
                m_cap = 0; m_armed = 0;
            end else if (ws) begin
                m_n++;
                if (m_n == ENTRIES - te) m_armed = 1;
                if (was && trg) begin
                    m_post++;
                    if (m_post == te) begin
                        m_pulse = 1; m_armed = 0; m_taddr = m_n % ENTRIES;
                        m_cap = 0; m_wait = 1;
                    end
                end
            end
        end else if (m_wait) begin
            if (cd) m_wait = 0;
        end else if (r && !cd) begin
            m_cap = 1; m_n = 0; m_post = 0; m_armed = 0;
        end
    endfunction

    task automatic check_outs(input bit r, input bit ws);
        chk("we", bus.we, (m_cap && r && ws));
        chk("waddr", bus.waddr, m_n % ENTRIES);
        chk("armed", bus.armed, m_armed);
        chk("set_capture_done", bus.set_capture_done, m_pulse);
        chk("trig_addr", bus.trig_addr, m_taddr);
    endtask

    task automatic cyc(input bit r, input bit cd, input bit ws, input bit trg, input int tp);
        bus.run = r; bus.capture_done = cd; bus.wrt_smpl = ws;
        bus.triggered = trg; bus.trig_pos = AW'(tp);
        #1;
        check_outs(r, ws);
        if (bus.armed === 1'b1 && arm_n < 0) arm_n = n_we;
        if (bus.set_capture_done === 1'b1) begin
            pulse_cnt++;
            if (done_n < 0) done_n = n_we;
        end
        if (bus.we === 1'b1) n_we++;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(r, cd, ws, trg, tp);
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outs(1'b0, 1'b0);
        bus.run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One capture run driven like the host + trigger stage would.
    // mode: 0 dense, 1 every 4th cycle, 2 random strobes.
    // trig_w: strobe number on which triggered first rises (0: right after armed).
    task automatic capture(input int tp, input int mode, input int trig_w,
                           input int abort_w, input int rst_w);
        bit r, cd, trg, ws, post, ab, fin, pl;
        int k, tail, tw;
        r = 1; cd = 0; trg = 0; post = 0; ab = 0; fin = 0; k = 0; tail = 0;
        tw = (trig_w == 0) ? ENTRIES - eff(tp) + 1 : trig_w;
        arm_n = -1; done_n = -1; n_we = 0; pulse_cnt = 0;
        while (!fin && k < 20000) begin
            case (mode)
                0:       ws = 1'b1;
                1:       ws = (k % 4 == 3);
                default: ws = 1'($urandom_range(0, 1));
            endcase
            if (post) begin
                trg = 0; cd = (tail >= 3 && tail <= 4); r = (tail >= 3);
            end else if (ab) begin
                r = 0; cd = 0; trg = 0;
            end else begin
                if (m_cap && m_n + 1 >= tw) trg = 1;
                if (rst_w > 0 && m_cap && m_n == rst_w) begin
                    async_reset();
                    fin = 1;
                    break;
                end
                if (abort_w > 0 && m_cap && m_n == abort_w) begin
                    r = 0; ws = 1; ab = 1; tail = 4;
                end
            end
            pl = m_pulse;
            cyc(r, cd, ws, trg, tp);
            k++;
            if (pl && !post) begin post = 1; tail = 8; end
            if (tail > 0) begin
                tail--;
                if (tail == 0) fin = 1;
            end
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    initial begin
        int cnt;
        model_reset();
        rst_n = 1'b0;
        bus.run = 0; bus.capture_done = 0; bus.wrt_smpl = 0;
        bus.triggered = 0; bus.trig_pos = '0;
        @(negedge clk);
        // Reset held with run=1 and strobes toggling: outputs stay at reset values
        for (int i = 0; i < 4; i++) cyc(1, 0, 1'(i % 2), 0, 100);
        rst_n = 1'b1;
        cyc(1, 0, 1, 0, 100);
        chk("first_we_after_reset", n_we, 0);
        cyc(0, 0, 0, 0, 100);  // abort back to IDLE
        cyc(0, 0, 0, 0, 100);

        // Normal dense capture
        capture(100, 0, 0, 0, 0);
        chk("dense_arm_n", arm_n, 284);
        chk("dense_done_n", done_n, 384);
        chk("dense_pulses", pulse_cnt, 1);
        chk("dense_trig_addr", bus.trig_addr, 0);
        chk("dense_armed", bus.armed, 0);

        // Wrap with long pre-trigger
        capture(10, 0, 1000, 0, 0);
        chk("wrap_arm_n", arm_n, 374);
        chk("wrap_done_n", done_n, 1009);
        chk("wrap_trig_addr", bus.trig_addr, 241);

        // Sparse strobes
        capture(100, 1, 0, 0, 0);
        chk("sparse_arm_n", arm_n, 284);
        chk("sparse_done_n", done_n, 384);
        chk("sparse_trig_addr", bus.trig_addr, 0);

        // Abort at write 200, then re-run restarts at 0
        capture(100, 0, 0, 200, 0);
        chk("abort_pulses", pulse_cnt, 0);
        chk("abort_armed", bus.armed, 0);
        chk("abort_waddr_held", bus.waddr, 200);
        cyc(1, 0, 0, 0, 100);
        chk("rerun_waddr", bus.waddr, 0);
        cyc(0, 0, 0, 0, 100);

        // trig_pos = 0 behaves as 1
        capture(0, 0, 0, 0, 0);
        chk("tp0_arm_n", arm_n, 383);
        chk("tp0_done_n", done_n, 384);
        chk("tp0_trig_addr", bus.trig_addr, 0);

        // trig_pos beyond RAM depth clamps to ENTRIES-1
        capture(450, 0, 0, 0, 0);
        chk("tpbig_arm_n", arm_n, 1);
        chk("tpbig_done_n", done_n, 384);

        // capture_done high blocks a new capture
        n_we = 0;
        for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0, 100);
        chk("cd_block_we", n_we, 0);
        cyc(0, 0, 0, 0, 100);

        // Async reset mid-capture
        capture(100, 0, 0, 0, 150);
        cnt = pulse_cnt;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 100);
        chk("reset_no_pulse", pulse_cnt, cnt);

        // Randomized captures
        for (int t = 0; t < 8; t++) begin
            int tp, thr, tw, aw, rw;
            tp  = $urandom_range(0, 511);
            thr = ENTRIES - eff(tp);
            tw  = thr + 1 + $urandom_range(0, 400);
            aw  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tw) : 0;
            rw  = (aw == 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, tw) : 0;
            capture(tp, $urandom_range(0, 2), tw, aw, rw);
            cyc(0, 0, 0, 0, tp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
